// File: rtl/ifm_addr_pkg.sv
// rtl/ifm_addr_pkg.sv - shared state, config and sizing definitions for the IFM window address generator
package ifm_addr_pkg;

    localparam int unsigned CFG_ADDR_W = 20;
    localparam int unsigned CFG_DIM_W  = 9;
    localparam int unsigned CFG_K_W    = 3;
    localparam int unsigned CFG_S_W    = 2;
    localparam int unsigned K_MAX      = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic [CFG_ADDR_W-1:0] base;
        logic [CFG_DIM_W-1:0]  ifm_w;
        logic [CFG_DIM_W-1:0]  ifm_h;
        logic [CFG_DIM_W-1:0]  ch;
        logic [CFG_K_W-1:0]    k;
        logic [CFG_S_W-1:0]    stride;
        logic [CFG_DIM_W-1:0]  ofm_w;
        logic [CFG_DIM_W-1:0]  ofm_h;
    } cfg_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - loop counter that wraps to zero after reaching a run-time limit
module wrap_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] value_o,
    output logic             at_limit_o
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    assign at_limit_o = (value_q == limit_i);
    assign value_o    = value_q;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = '0;
        end else if (inc_i) begin
            value_d = at_limit_o ? '0 : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/ifm_window_addr_gen.sv
// rtl/ifm_window_addr_gen.sv - walks every KxK window over all channels for each OFM pixel, emitting IFM read addresses
module ifm_window_addr_gen
    import ifm_addr_pkg::*;
#(
    parameter int unsigned ADDR_W = CFG_ADDR_W,
    parameter int unsigned DIM_W  = CFG_DIM_W,
    parameter int unsigned K_W    = CFG_K_W,
    parameter int unsigned S_W    = CFG_S_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [DIM_W-1:0]  cfg_ifm_w,
    input  logic [DIM_W-1:0]  cfg_ifm_h,
    input  logic [DIM_W-1:0]  cfg_ch,
    input  logic [K_W-1:0]    cfg_k,
    input  logic [S_W-1:0]    cfg_stride,
    input  logic [DIM_W-1:0]  cfg_ofm_w,
    input  logic [DIM_W-1:0]  cfg_ofm_h,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_last,
    output logic              done,
    output logic              busy
);

    state_e state_q, state_d;
    cfg_t   cfg_q, cfg_in;

    logic [ADDR_W-1:0] plane_q, plane_d;
    logic [ADDR_W-1:0] row_step_q, row_step_d;
    logic [ADDR_W-1:0] row_start_q, row_start_d;
    logic [ADDR_W-1:0] win_base_q, win_base_d;
    logic [ADDR_W-1:0] ch_base_q, ch_base_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;

    logic [K_W-1:0]   kx, ky, k_lim;
    logic [DIM_W-1:0] c_cnt, ox, oy, c_lim, ox_lim, oy_lim;
    logic             kx_at, ky_at, c_at, ox_at, oy_at;
    logic             xfer, clr, final_beat, empty_job;

    logic [ADDR_W-1:0] w_ext, s_ext, kx_ext, base_ext;
    logic [ADDR_W-1:0] row_next, ch_next, win_next, rs_next;

    assign cfg_in.base   = CFG_ADDR_W'(cfg_base);
    assign cfg_in.ifm_w  = CFG_DIM_W'(cfg_ifm_w);
    assign cfg_in.ifm_h  = CFG_DIM_W'(cfg_ifm_h);
    assign cfg_in.ch     = CFG_DIM_W'(cfg_ch);
    assign cfg_in.k      = CFG_K_W'(cfg_k);
    assign cfg_in.stride = CFG_S_W'(cfg_stride);
    assign cfg_in.ofm_w  = CFG_DIM_W'(cfg_ofm_w);
    assign cfg_in.ofm_h  = CFG_DIM_W'(cfg_ofm_h);

    assign k_lim  = K_W'(cfg_q.k) - K_W'(1);
    assign c_lim  = DIM_W'(cfg_q.ch) - DIM_W'(1);
    assign ox_lim = DIM_W'(cfg_q.ofm_w) - DIM_W'(1);
    assign oy_lim = DIM_W'(cfg_q.ofm_h) - DIM_W'(1);

    assign xfer       = (state_q == RUN) && addr_ready;
    assign clr        = (state_q == LOAD);
    assign final_beat = xfer && kx_at && ky_at && c_at && ox_at && oy_at;
    assign empty_job  = (cfg_q.k == '0) || (cfg_q.ch == '0) ||
                        (cfg_q.ofm_w == '0) || (cfg_q.ofm_h == '0);

    // Each counter steps only when every inner loop is at its limit on a transfer.
    wrap_counter #(.WIDTH(K_W)) u_kx (
        .clk_i(clk), .rst_n_i(reset_n), .clr_i(clr), .inc_i(xfer),
        .limit_i(k_lim), .value_o(kx), .at_limit_o(kx_at)
    );
    wrap_counter #(.WIDTH(K_W)) u_ky (
        .clk_i(clk), .rst_n_i(reset_n), .clr_i(clr), .inc_i(xfer && kx_at),
        .limit_i(k_lim), .value_o(ky), .at_limit_o(ky_at)
    );
    wrap_counter #(.WIDTH(DIM_W)) u_c (
        .clk_i(clk), .rst_n_i(reset_n), .clr_i(clr), .inc_i(xfer && kx_at && ky_at),
        .limit_i(c_lim), .value_o(c_cnt), .at_limit_o(c_at)
    );
    wrap_counter #(.WIDTH(DIM_W)) u_ox (
        .clk_i(clk), .rst_n_i(reset_n), .clr_i(clr), .inc_i(xfer && kx_at && ky_at && c_at),
        .limit_i(ox_lim), .value_o(ox), .at_limit_o(ox_at)
    );
    wrap_counter #(.WIDTH(DIM_W)) u_oy (
        .clk_i(clk), .rst_n_i(reset_n), .clr_i(clr),
        .inc_i(xfer && kx_at && ky_at && c_at && ox_at),
        .limit_i(oy_lim), .value_o(oy), .at_limit_o(oy_at)
    );

    assign w_ext    = ADDR_W'(cfg_q.ifm_w);
    assign s_ext    = ADDR_W'(cfg_q.stride);
    assign kx_ext   = ADDR_W'(kx);
    assign base_ext = ADDR_W'(cfg_q.base);
    assign row_next = row_base_q + w_ext;
    assign ch_next  = ch_base_q + plane_q;
    assign win_next = win_base_q + s_ext;
    assign rs_next  = row_start_q + row_step_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = empty_job ? DONE : RUN;
            RUN:     if (final_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        plane_d     = plane_q;
        row_step_d  = row_step_q;
        row_start_d = row_start_q;
        win_base_d  = win_base_q;
        ch_base_d   = ch_base_q;
        row_base_d  = row_base_q;
        if (state_q == LOAD) begin
            plane_d     = ADDR_W'(cfg_q.ifm_w) * ADDR_W'(cfg_q.ifm_h);
            row_step_d  = s_ext * w_ext;
            row_start_d = base_ext;
            win_base_d  = base_ext;
            ch_base_d   = base_ext;
            row_base_d  = base_ext;
        end else if (xfer && kx_at) begin
            if (!ky_at) begin
                row_base_d = row_next;
            end else if (!c_at) begin
                ch_base_d  = ch_next;
                row_base_d = ch_next;
            end else if (!ox_at) begin
                win_base_d = win_next;
                ch_base_d  = win_next;
                row_base_d = win_next;
            end else if (!oy_at) begin
                row_start_d = rs_next;
                win_base_d  = rs_next;
                ch_base_d   = rs_next;
                row_base_d  = rs_next;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            plane_q     <= '0;
            row_step_q  <= '0;
            row_start_q <= '0;
            win_base_q  <= '0;
            ch_base_q   <= '0;
            row_base_q  <= '0;
        end else begin
            state_q     <= state_d;
            if (state_q == IDLE && start) cfg_q <= cfg_in;
            plane_q     <= plane_d;
            row_step_q  <= row_step_d;
            row_start_q <= row_start_d;
            win_base_q  <= win_base_d;
            ch_base_q   <= ch_base_d;
            row_base_q  <= row_base_d;
        end
    end

    assign addr_valid = (state_q == RUN);
    assign addr       = addr_valid ? row_base_q + kx_ext : '0;
    assign win_last   = addr_valid && kx_at && ky_at && c_at;
    assign done       = (state_q == DONE);
    assign busy       = (state_q == LOAD) || (state_q == RUN);

endmodule
